// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg
//   Shared definitions for the SIMPLE processor phase sequencer: state encoding
//   (IDLE, P1..P5, HALT), phase-index constants and small decode helpers that
//   debug/trace logic can reuse to interpret the sequencer state.
package phase_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    // State encoding. P1..P5 are contiguous so "running" is a range test.
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_P1   = 3'd1;
    localparam logic [STATE_W-1:0] ST_P2   = 3'd2;
    localparam logic [STATE_W-1:0] ST_P3   = 3'd3;
    localparam logic [STATE_W-1:0] ST_P4   = 3'd4;
    localparam logic [STATE_W-1:0] ST_P5   = 3'd5;
    localparam logic [STATE_W-1:0] ST_HALT = 3'd6;

    // Bit positions of each phase inside the {p5,p4,p3,p2,p1} strobe vector.
    localparam int unsigned PH_FETCH  = 0;
    localparam int unsigned PH_DECODE = 1;
    localparam int unsigned PH_EXEC   = 2;
    localparam int unsigned PH_MEM    = 3;
    localparam int unsigned PH_WB     = 4;
    localparam int unsigned NUM_PHASES = 5;

    // Wait counter width; WAIT_MAX is limited to 1..255.
    localparam int unsigned WAIT_CNT_W = 8;

    function automatic logic [NUM_PHASES-1:0] phase_strobes(input logic [STATE_W-1:0] st);
        logic [NUM_PHASES-1:0] s;
        s = '0;
        case (st)
            ST_P1:   s[PH_FETCH]  = 1'b1;
            ST_P2:   s[PH_DECODE] = 1'b1;
            ST_P3:   s[PH_EXEC]   = 1'b1;
            ST_P4:   s[PH_MEM]    = 1'b1;
            ST_P5:   s[PH_WB]     = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic state_is_running(input logic [STATE_W-1:0] st);
        return (st >= ST_P1) && (st <= ST_P5);
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Central five-phase sequencer for the SIMPLE processor. Produces one-cycle
//   phase strobes p1..p5 (fetch, decode/reg-read, execute, memory, writeback)
//   from a single system clock, one instruction at a time. Handles run/stop,
//   HLT-driven halt, memory-wait stretching of P3/P4 with timeout, and counts
//   retired instructions.
//
//   Optional feature macro: PHASE_STEP_EN
//     defined   -> 'step' starts a single instruction from IDLE
//     undefined -> 'step' is ignored; only 'run' starts execution
//
// Ports
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   run        in   start/continue execution (level)
//   stop       in   stop at next instruction boundary
//   step       in   single-step from IDLE (PHASE_STEP_EN only)
//   halt_dec   in   decode saw HLT, honoured only in P2
//   memwait    in   memory busy, stretches P3/P4
//   p1..p5     out  phase strobes, one-hot or all zero
//   running    out  state is one of P1..P5
//   halted     out  state is HALT
//   timeout    out  sticky memwait timeout flag
//   instcount  out  retired-instruction count (wraps)
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run,
    input  logic             stop,
    input  logic             step,
    input  logic             halt_dec,
    input  logic             memwait,
    output logic             p1,
    output logic             p2,
    output logic             p3,
    output logic             p4,
    output logic             p5,
    output logic             running,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] instcount
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]      CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_nxt;
    logic                  r_halt_pend;
    logic                  w_halt_pend_nxt;
    logic                  r_stop_pend;
    logic                  w_stop_pend_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
    logic                  r_timeout;
    logic                  w_timeout_nxt;
    logic [CNT_W-1:0]      r_instcount;
    logic [CNT_W-1:0]      w_instcount_nxt;

    logic                  w_active;
    logic                  w_step_req;
    logic                  w_step_mode;
    logic                  w_step_mode_nxt;
    logic [NUM_PHASES-1:0] w_strobes;

`ifdef PHASE_STEP_EN
    logic r_step_mode;

    assign w_step_req  = step;
    assign w_step_mode = r_step_mode;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_step_mode <= 1'b0;
        end else begin
            r_step_mode <= w_step_mode_nxt;
        end
    end
`else
    logic w_unused_step;
    logic w_unused_step_mode_nxt;

    assign w_step_req             = 1'b0;
    assign w_step_mode            = 1'b0;
    assign w_unused_step          = step;
    assign w_unused_step_mode_nxt = w_step_mode_nxt;
`endif

    assign w_active = state_is_running(r_state);

    always_comb begin
        w_state_nxt     = r_state;
        w_halt_pend_nxt = r_halt_pend;
        w_stop_pend_nxt = r_stop_pend;
        w_step_mode_nxt = w_step_mode;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_timeout_nxt   = r_timeout;
        w_instcount_nxt = r_instcount;

        if (w_active && stop) begin
            w_stop_pend_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                // run has priority over step and forces a free-running start
                if (run) begin
                    w_state_nxt     = ST_P1;
                    w_step_mode_nxt = 1'b0;
                end else if (w_step_req) begin
                    w_state_nxt     = ST_P1;
                    w_step_mode_nxt = 1'b1;
                end
            end
            ST_P1: begin
                w_state_nxt = ST_P2;
            end
            ST_P2: begin
                w_state_nxt = ST_P3;
                if (halt_dec) begin
                    w_halt_pend_nxt = 1'b1;
                end
            end
            ST_P3, ST_P4: begin
                if (memwait) begin
                    // WAIT_MAX wait cycles are tolerated; one more is a timeout
                    if (r_wait_cnt == WAIT_LIMIT) begin
                        w_state_nxt    = ST_HALT;
                        w_timeout_nxt  = 1'b1;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = (r_state == ST_P3) ? ST_P4 : ST_P5;
                end
            end
            ST_P5: begin
                w_instcount_nxt = r_instcount + CNT_ONE;
                // stop raised during P5 itself still ends at this boundary
                if (r_halt_pend) begin
                    w_state_nxt = ST_HALT;
                end else if (r_stop_pend || stop || w_step_mode || !run) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_P1;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_IDLE) begin
            w_stop_pend_nxt = 1'b0;
            w_step_mode_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_halt_pend <= 1'b0;
            r_stop_pend <= 1'b0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_instcount <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
            r_instcount <= w_instcount_nxt;
        end
    end

    // All outputs decode registered state only.
    assign w_strobes = phase_strobes(r_state);
    assign p1        = w_strobes[PH_FETCH];
    assign p2        = w_strobes[PH_DECODE];
    assign p3        = w_strobes[PH_EXEC];
    assign p4        = w_strobes[PH_MEM];
    assign p5        = w_strobes[PH_WB];
    assign running   = w_active;
    assign halted    = (r_state == ST_HALT);
    assign timeout   = r_timeout;
    assign instcount = r_instcount;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned WAIT_MAX = 15;

    logic             clock = 1'b0;
    logic             resetn;
    logic             run, stop, step, halt_dec, memwait;
    logic             p1, p2, p3, p4, p5;
    logic             running, halted, timeout;
    logic [CNT_W-1:0] instcount;
    logic [4:0]       ph;

    assign ph = {p5, p4, p3, p2, p1};

    phase_sequencer #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .stop      (stop),
        .step      (step),
        .halt_dec  (halt_dec),
        .memwait   (memwait),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .p4        (p4),
        .p5        (p5),
        .running   (running),
        .halted    (halted),
        .timeout   (timeout),
        .instcount (instcount)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]       ph;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic sb_en  = 1'b1;
    int   exp_cnt;

    localparam logic [4:0] PH1 = 5'b00001;
    localparam logic [4:0] PH2 = 5'b00010;
    localparam logic [4:0] PH3 = 5'b00100;
    localparam logic [4:0] PH4 = 5'b01000;
    localparam logic [4:0] PH5 = 5'b10000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [4:0] p, input int cnt);
        exp_t e;
        e.ph  = p;
        e.cnt = CNT_W'(cnt);
        sb_q.push_back(e);
    endtask

    // Expected strobe trace of one instruction with w3/w4 memwait cycles.
    task automatic push_instr(input int cnt, input int w3, input int w4);
        push(PH1, cnt);
        push(PH2, cnt);
        for (int i = 0; i <= w3; i++) push(PH3, cnt);
        for (int i = 0; i <= w4; i++) push(PH4, cnt);
        push(PH5, cnt);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        run = 0; stop = 0; step = 0; halt_dec = 0; memwait = 0;
        tick(2);
        chk("rst_strobes", 32'(ph), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_instcount", 32'(instcount), 0);
        resetn = 1'b1;
    endtask

    initial begin
        fork
            // Monitor: every running cycle must match the next expected strobe.
            forever begin
                @(negedge clock);
                if (sb_en) begin
                    if (running) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_unexpected_phase", 32'(ph), 0);
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            chk("sb_strobes", 32'(ph), 32'(e.ph));
                            chk("sb_instcount", 32'(instcount), 32'(e.cnt));
                        end
                    end else begin
                        chk("idle_strobes", 32'(ph), 0);
                    end
                end
            end
        join_none

        do_reset();

        // Two back-to-back instructions, run dropped during the second P5.
        push_instr(0, 0, 0);
        push_instr(1, 0, 0);
        run = 1;
        tick(10);
        run = 0;
        tick(2);
        chk("b2b_instcount", 32'(instcount), 2);
        chk("b2b_idle", 32'(running), 0);
        exp_cnt = 2;

        // Three memwait cycles in P4; halt_dec outside P2 must be ignored.
        push_instr(exp_cnt, 0, 3);
        run = 1;
        tick(1);
        run = 0;
        tick(3);
        memwait = 1; halt_dec = 1;
        tick(3);
        memwait = 0; halt_dec = 0;
        tick(3);
        exp_cnt++;
        chk("wait4_instcount", 32'(instcount), 32'(exp_cnt));
        chk("wait4_not_halted", 32'(halted), 0);

        // Stop pulse in P3 with run held: back to IDLE, then restart.
        push_instr(exp_cnt, 0, 0);
        push_instr(exp_cnt + 1, 0, 0);
        run = 1;
        tick(3);
        stop = 1;
        tick(1);
        stop = 0;
        tick(2);
        @(negedge clock);
        chk("stop_idle", 32'(running), 0);
        chk("stop_instcount", 32'(instcount), 32'(exp_cnt + 1));
        tick(2);
        run = 0;
        tick(5);
        exp_cnt += 2;
        chk("restart_instcount", 32'(instcount), 32'(exp_cnt));

        // Single step from IDLE.
`ifdef PHASE_STEP_EN
        push_instr(exp_cnt, 0, 0);
        step = 1;
        tick(1);
        step = 0;
        tick(6);
        exp_cnt++;
        chk("step_instcount", 32'(instcount), 32'(exp_cnt));
        chk("step_idle", 32'(running), 0);
`else
        step = 1;
        tick(1);
        step = 0;
        tick(4);
        chk("step_ignored_idle", 32'(running), 0);
        chk("step_ignored_cnt", 32'(instcount), 32'(exp_cnt));
`endif

        // HLT decoded in P2: finish the instruction, then HALT forever.
        push_instr(exp_cnt, 0, 0);
        run = 1;
        tick(2);
        halt_dec = 1;
        tick(1);
        halt_dec = 0;
        tick(3);
        @(negedge clock);
        exp_cnt++;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_running", 32'(running), 0);
        chk("halt_instcount", 32'(instcount), 32'(exp_cnt));
        step = 1; stop = 1;
        tick(4);
        chk("halt_absorbing", 32'(halted), 1);
        chk("halt_cnt_frozen", 32'(instcount), 32'(exp_cnt));
        run = 0; step = 0; stop = 0;

        // memwait held in P3 until timeout.
        do_reset();
        sb_en = 1'b0;
        begin
            int  p3_cycles;
            bit  late_phase;
            bit  seen_halt;
            p3_cycles  = 0;
            late_phase = 0;
            seen_halt  = 0;
            run = 1; memwait = 1;
            tick(1);
            run = 0;
            for (int i = 0; i < 40 && !seen_halt; i++) begin
                @(negedge clock);
                if (p3) p3_cycles++;
                if (p4 || p5) late_phase = 1;
                if (halted) seen_halt = 1;
            end
            chk("to_halted", 32'(seen_halt), 1);
            chk("to_timeout", 32'(timeout), 1);
            chk("to_instcount", 32'(instcount), 0);
            chk("to_no_p4_p5", 32'(late_phase), 0);
            chk("to_p3_len_ok", 32'((p3_cycles >= int'(WAIT_MAX)) &&
                                    (p3_cycles <= int'(WAIT_MAX) + 1)), 1);
            memwait = 0;
        end
        sb_en = 1'b1;

        // Reset asserted mid-P3 clears strobes immediately, no retire.
        do_reset();
        push(PH1, 0);
        push(PH2, 0);
        push(PH3, 0);
        run = 1;
        tick(3);
        @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_strobes", 32'(ph), 0);
        chk("async_rst_running", 32'(running), 0);
        run = 0;
        tick(2);
        resetn = 1'b1;
        tick(3);
        chk("async_rst_instcount", 32'(instcount), 0);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
